// File: rtl/read_buffer_scheduler.sv
// Read-buffer sequencing controller for the 3x3 filter window.
// Walks the frame as 8-pixel-wide vertical strips (6-column step), filling the
// 3-row buffer over Avalon-MM single-word reads and handing each window to the filter.
//
// Ports:
//   clk_i                  system clock
//   rst_i                  synchronous active-high reset
//   start_i                begin a frame (only honoured when idle)
//   pixel_done_i           filter finished one output pixel
//   master_waitrequest_i   Avalon-MM slave stall
//   master_readdatavalid_i Avalon-MM read data valid
//   master_address_o       Avalon-MM byte address
//   master_read_o          Avalon-MM read request
//   shift_enable24_o       buffer: returned word into line1 cascade (FILL)
//   load_read_buffer_o     buffer: returned word into staging row (LOAD)
//   shift_enable8_o        buffer: staging row into line1 (SHIFT)
//   filter_start_o         one-cycle pulse, window valid
//   busy_o                 frame in progress
//   frame_done_o           one-cycle pulse after the last window
module read_buffer_scheduler #(
  parameter int unsigned IMG_WIDTH       = 640,
  parameter int unsigned IMG_HEIGHT      = 480,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned BYTES_PER_PIXEL = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        pixel_done_i,
  input  logic        master_waitrequest_i,
  input  logic        master_readdatavalid_i,
  output logic [31:0] master_address_o,
  output logic        master_read_o,
  output logic        shift_enable24_o,
  output logic        load_read_buffer_o,
  output logic        shift_enable8_o,
  output logic        filter_start_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam bit Degenerate = (IMG_WIDTH < 8) || (IMG_HEIGHT < 3);

  typedef enum logic [2:0] {StIdle, StFill, StProc, StLoad, StShift, StNextStrip} state_e;

  state_e      state_q, state_d;
  logic [31:0] col_q, col_d;
  logic [31:0] row_q, row_d;       // window top row
  logic [4:0]  cnt_q, cnt_d;       // words received (FILL/LOAD) or shift cycles (SHIFT)
  logic [2:0]  pd_cnt_q, pd_cnt_d;
  logic        rd_q, rd_d;
  logic        outst_q, outst_d;   // one read issued, data not yet returned
  logic [31:0] addr_q, addr_d;
  logic        fs_q, fs_d;
  logic        busy_q, busy_d;
  logic        fd_q, fd_d;

  logic        issue;
  logic        rdv_ok;
  logic [4:0]  words_tgt;
  logic [31:0] req_row;
  logic [31:0] req_k;

  always_comb begin
    issue     = rd_q & ~master_waitrequest_i;
    // readdatavalid only counts when a read is actually outstanding
    rdv_ok    = outst_q & master_readdatavalid_i;
    words_tgt = (state_q == StFill) ? 5'd24 : 5'd8;
    req_row   = row_q + ((state_q == StFill) ? {30'd0, cnt_q[4:3]} : 32'd3);
    req_k     = {29'd0, cnt_q[2:0]};
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    pd_cnt_d = pd_cnt_q;
    rd_d     = rd_q & master_waitrequest_i;  // hold request until accepted
    addr_d   = addr_q;
    outst_d  = (outst_q & ~master_readdatavalid_i) | issue;
    busy_d   = busy_q;
    fd_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          col_d    = '0;
          row_d    = '0;
          cnt_d    = '0;
          pd_cnt_d = '0;
          if (Degenerate) begin
            fd_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = StFill;
          end
        end
      end
      StFill, StLoad: begin
        if (rdv_ok) begin
          if (cnt_q == words_tgt - 5'd1) begin
            cnt_d   = '0;
            state_d = (state_q == StFill) ? StProc : StShift;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else if (!rd_q && !outst_q) begin
          rd_d   = 1'b1;
          addr_d = BASE_ADDR + BYTES_PER_PIXEL * (req_row * IMG_WIDTH + col_q + req_k);
        end
      end
      StProc: begin
        if (pixel_done_i) begin
          if (pd_cnt_q == 3'd5) begin
            pd_cnt_d = '0;
            state_d  = (row_q + 32'd3 < IMG_HEIGHT) ? StLoad : StNextStrip;
          end else begin
            pd_cnt_d = pd_cnt_q + 3'd1;
          end
        end
      end
      StShift: begin
        if (cnt_q == 5'd7) begin
          cnt_d   = '0;
          row_d   = row_q + 32'd1;
          state_d = StProc;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StNextStrip: begin
        col_d = col_q + 32'd6;
        row_d = '0;
        if (col_q + 32'd14 <= IMG_WIDTH) begin
          state_d = StFill;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
          fd_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    fs_d = (state_d == StProc) && (state_q != StProc);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      col_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      pd_cnt_q <= '0;
      rd_q     <= 1'b0;
      outst_q  <= 1'b0;
      addr_q   <= '0;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      pd_cnt_q <= pd_cnt_d;
      rd_q     <= rd_d;
      outst_q  <= outst_d;
      addr_q   <= addr_d;
      fs_q     <= fs_d;
      busy_q   <= busy_d;
      fd_q     <= fd_d;
    end
  end

  assign master_address_o   = addr_q;
  assign master_read_o      = rd_q;
  assign shift_enable24_o   = (state_q == StFill);
  assign load_read_buffer_o = (state_q == StLoad);
  assign shift_enable8_o    = (state_q == StShift);
  assign filter_start_o     = fs_q;
  assign busy_o             = busy_q;
  assign frame_done_o       = fd_q;

endmodule

// File: tb/tb_read_buffer_scheduler.sv
// Bench for read_buffer_scheduler: a 14x4 frame instance driven by a slave/filter
// model, plus a 7-pixel-wide instance for the degenerate case.
module tb_read_buffer_scheduler;

  localparam int unsigned W    = 14;
  localparam int unsigned H    = 4;
  localparam int unsigned BPP  = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef enum int {PIdle, PFill, PWin, PLoad, PShift, PGap} ph_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, pd = 1'b0, wr = 1'b0, rdv = 1'b0;
  logic [31:0] addr;
  logic rd, se24, lrb, se8, fs, busy, fd;

  logic start2 = 1'b0;
  logic [31:0] addr2;
  logic rd2, se24_2, lrb2, se8_2, fs2, busy2, fd2;

  read_buffer_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BASE_ADDR(BASE),
                          .BYTES_PER_PIXEL(BPP)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pixel_done_i(pd),
    .master_waitrequest_i(wr), .master_readdatavalid_i(rdv),
    .master_address_o(addr), .master_read_o(rd), .shift_enable24_o(se24),
    .load_read_buffer_o(lrb), .shift_enable8_o(se8), .filter_start_o(fs),
    .busy_o(busy), .frame_done_o(fd)
  );

  read_buffer_scheduler #(.IMG_WIDTH(7), .IMG_HEIGHT(4), .BASE_ADDR(BASE),
                          .BYTES_PER_PIXEL(BPP)) dut_deg (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .pixel_done_i(1'b0),
    .master_waitrequest_i(1'b0), .master_readdatavalid_i(1'b0),
    .master_address_o(addr2), .master_read_o(rd2), .shift_enable24_o(se24_2),
    .load_read_buffer_o(lrb2), .shift_enable8_o(se8_2), .filter_start_o(fs2),
    .busy_o(busy2), .frame_done_o(fd2)
  );

  int checks = 0, errors = 0;

  // Reference model state
  ph_e mph = PIdle;
  int  got, pd_cnt, sh, wrow, mcol;
  bit  first, outst, issue_now, hold, req_active, fd_exp, rand_mode;
  logic [31:0] hold_addr;
  logic [31:0] exp_q[$];
  int  lat_cnt, issue_idx, stall_idx = -1, stall_left;
  int  n_issue, n_fs, n_pd, n_fd, n_hold;
  bit  start_req, rst_req = 1'b1, late_rdv_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Full frame read order: per strip, 3 fill rows then one new row per window step.
  function automatic void build_q();
    exp_q.delete();
    for (int c = 0; c + 8 <= int'(W); c += 6)
      for (int r = 0; r < int'(H); r++)
        for (int k = 0; k < 8; k++)
          exp_q.push_back(BASE + BPP * (r * W + c + k));
  endfunction

  function automatic void model_reset();
    mph = PIdle; outst = 0; issue_now = 0; hold = 0; req_active = 0;
    stall_left = 0; first = 0; exp_q.delete();
  endfunction

  task automatic tick();
    ph_e old;
    bit  valid;
    logic [5:0] ev;
    @(posedge clk); #1;
    old    = mph;
    fd_exp = 0;
    if (rst) begin
      model_reset();
    end else begin
      valid = rdv && outst;
      if (valid) outst = 0;
      if (issue_now) begin
        outst   = 1;
        lat_cnt = rand_mode ? int'($urandom_range(3, 1)) : 1;
      end
      issue_now = 0;
      case (old)
        PIdle: if (start) begin
          mph = PFill; got = 0; mcol = 0; wrow = 0; issue_idx = 0; build_q();
        end
        PFill: if (valid) begin
          got++;
          if (got == 24) begin mph = PWin; pd_cnt = 0; first = 1; end
        end
        PWin: begin
          first = 0;
          if (pd) begin
            pd_cnt++; n_pd++;
            if (pd_cnt == 6) begin
              mph = (wrow + 3 < int'(H)) ? PLoad : PGap;
              got = 0;
            end
          end
        end
        PLoad: if (valid) begin
          got++;
          if (got == 8) begin mph = PShift; sh = 0; end
        end
        PShift: begin
          sh++;
          if (sh == 8) begin mph = PWin; wrow++; first = 1; pd_cnt = 0; end
        end
        PGap: begin
          mcol += 6; wrow = 0;
          if (mcol + 8 <= int'(W)) begin mph = PFill; got = 0; end
          else begin mph = PIdle; fd_exp = 1; end
        end
        default: mph = PIdle;
      endcase
    end

    // Expected {se24, lrb, se8, filter_start, busy, frame_done}
    case (mph)
      PFill:   ev = 6'b100010;
      PWin:    ev = {3'b000, first, 2'b10};
      PLoad:   ev = 6'b010010;
      PShift:  ev = 6'b001010;
      PGap:    ev = 6'b000010;
      default: ev = {5'b00000, fd_exp};
    endcase
    chk("ctl", {26'd0, se24, lrb, se8, fs, busy, fd}, {26'd0, ev});
    if (fs) n_fs++;
    if (fd) n_fd++;
    if (hold) begin
      chk("hold_rd", rd, 1);
      chk("hold_addr", addr, hold_addr);
      hold = 0;
    end
    chk("rd_legal", rd && !((mph == PFill || mph == PLoad) && !outst), 0);

    // Drive inputs for the next edge
    wr = 0; rdv = 0;
    if (rd && !outst && (mph == PFill || mph == PLoad)) begin
      if (!req_active) begin
        req_active = 1;
        if (issue_idx == stall_idx) stall_left = 5;
      end
      if (stall_left > 0) begin wr = 1; stall_left--; end
      else if (rand_mode && $urandom_range(3) == 0) wr = 1;
      if (wr) begin
        hold = 1; hold_addr = addr; n_hold++;
      end else begin
        issue_now = 1; req_active = 0; issue_idx++; n_issue++;
        chk("addr_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("addr", addr, exp_q.pop_front());
      end
    end
    if (outst) begin
      if (lat_cnt <= 1) rdv = 1;
      else lat_cnt--;
    end else if (rand_mode && !issue_now && $urandom_range(7) == 0) begin
      rdv = 1;
    end
    if (late_rdv_req) begin rdv = 1; late_rdv_req = 0; end
    pd    = rand_mode ? 1'($urandom_range(1)) : 1'b1;
    start = start_req || (rand_mode && mph != PIdle && $urandom_range(31) == 0);
    start_req = 0;
    rst   = rst_req;
    rst_req = 0;
  endtask

  task automatic run_frame(input string tag);
    int n;
    n_issue = 0; n_fs = 0; n_pd = 0; n_fd = 0; n_hold = 0;
    start_req = 1;
    tick();
    n = 0;
    while (n_fd == 0 && n < 5000) begin tick(); n++; end
    chk({tag, "_finished"}, 32'(n_fd != 0), 1);
    repeat (5) tick();
    chk({tag, "_reads"}, n_issue, 64);
    chk({tag, "_filter_starts"}, n_fs, 4);
    chk({tag, "_pixel_done"}, n_pd, 24);
    chk({tag, "_frame_done"}, n_fd, 1);
    chk({tag, "_addr_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rand_mode = 0;
    tick();  // reset edge
    chk("reset_addr", addr, 0);
    chk("reset_rd", rd, 0);
    chk("reset_busy", busy, 0);
    repeat (2) tick();

    // Zero-wait, 1-cycle latency, pixel_done held high, 5-cycle stall on the 3rd read
    stall_idx = 2;
    run_frame("directed");
    chk("stall_cycles", n_hold, 5);
    stall_idx = -1;

    // Randomised stalls, latency, spurious pixel_done/readdatavalid/start
    rand_mode = 1;
    repeat (3) run_frame("random");

    // Reset while a LOAD read is outstanding
    start_req = 1;
    tick();
    n = 0;
    while (!(mph == PLoad && outst) && n < 5000) begin tick(); n++; end
    chk("reached_load", 32'(mph == PLoad && outst), 1);
    rst_req = 1;
    tick();
    tick();
    chk("rst_rd", rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);
    late_rdv_req = 1;
    repeat (3) tick();
    chk("late_rdv_rd", rd, 0);
    chk("late_rdv_busy", busy, 0);
    run_frame("restart");

    // Degenerate width: frame_done on the next cycle, no reads
    rand_mode = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("deg_frame_done", fd2, 1);
    chk("deg_busy", busy2, 0);
    chk("deg_rd", rd2, 0);
    tick();
    chk("deg_frame_done_pulse", fd2, 0);
    repeat (3) begin
      tick();
      chk("deg_quiet", {25'd0, rd2, se24_2, lrb2, se8_2, fs2, busy2, fd2}, 0);
      chk("deg_addr", addr2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_buffer_scheduler.md
Name: read_buffer_scheduler

Overview:
- Sequencing controller for the 3-row pixel read buffer that feeds the 3x3 filter window.
- Issues single-word Avalon-MM reads to frame memory and drives the buffer's shift_enable24, load_read_buffer and shift_enable8 controls.
- Hands each 3x8 window to the filter and waits for 6 pixel_done pulses before advancing.
- Frame is walked as vertical strips 8 pixels wide, stepping 6 columns per strip; within a strip the window steps down one row at a time.

Parameters:
IMG_WIDTH, 640, pixels per row
IMG_HEIGHT, 480, rows per frame
BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0)
BYTES_PER_PIXEL, 4, address stride per pixel (one 32-bit word per pixel)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begin frame (ignored unless IDLE)
pixel_done  input  1  filter finished one output pixel
master_waitrequest  input  1  Avalon-MM slave stall
master_readdatavalid  input  1  Avalon-MM read data valid
master_address  output  32  Avalon-MM byte address
master_read  output  1  Avalon-MM read request
shift_enable24  output  1  buffer: shift returned word into line1 cascade
load_read_buffer  output  1  buffer: shift returned word into staging row
shift_enable8  output  1  buffer: move staging row into line1 (one pixel per cycle)
filter_start  output  1  one-cycle pulse: window valid, filter may run
busy  output  1  high from start accepted until frame_done
frame_done  output  1  one-cycle pulse after last window finishes

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all outputs 0; master_address 0; all counters 0. Reset mid-transaction abandons outstanding reads, and any late readdatavalid is ignored in IDLE.
- Geometry: strip column col = 0,6,12,... while col+8 <= IMG_WIDTH. Window top row r = 0..IMG_HEIGHT-3. Columns beyond the last full strip are not processed.
- Address = BASE_ADDR + BYTES_PER_PIXEL*(row*IMG_WIDTH + col + k), k = 0..7. Computed in 32 bits, wrap ignored.
- Read protocol: at most one read outstanding.
  - master_read and master_address are held stable until a cycle with master_waitrequest=0 (the issue cycle).
  - master_read drops the next cycle.
  - The next read issues only after master_readdatavalid for the previous one.
- States:
  - IDLE: on start, col=0, r=0, busy<=1, go to FILL.
  - FILL:
    - Reads 24 words in order: row r k=0..7, row r+1 k=0..7, row r+2 k=0..7.
    - shift_enable24=1 for the whole state.
    - After the 24th readdatavalid, go to PROC.
  - PROC:
    - Entry cycle: filter_start=1 for exactly one cycle.
    - Count pixel_done pulses; a pulse in the entry cycle counts.
    - On the 6th pulse: if r+3 < IMG_HEIGHT go to LOAD; else go to NEXT_STRIP.
  - LOAD:
    - Reads 8 words of row r+3, k=0..7.
    - load_read_buffer=1 for the whole state.
    - After the 8th readdatavalid, go to SHIFT.
  - SHIFT:
    - shift_enable8=1 for exactly 8 consecutive cycles, with no read activity.
    - Then r<=r+1 and go to PROC.
  - NEXT_STRIP: col<=col+6, r<=0. If new col+8 <= IMG_WIDTH go to FILL; else frame_done=1 for one cycle, busy<=0, go to IDLE.
- Output exclusivity:
  - shift_enable24, load_read_buffer and shift_enable8 are mutually exclusive.
  - None of them is asserted outside its state.
  - master_read=0 in PROC and SHIFT.
- Spurious inputs:
  - pixel_done outside PROC is ignored.
  - readdatavalid with no outstanding read is ignored and does not advance counters.
- start while busy is ignored. start and rst together: rst wins.
- Degenerate frames: IMG_WIDTH<8 or IMG_HEIGHT<3 means start produces frame_done on the next cycle with no reads.

Test Plan:
- Reset during LOAD with a read outstanding -> next cycle all outputs 0, busy=0. A subsequent readdatavalid has no effect. A new start restarts at address BASE_ADDR.
- IMG_WIDTH=14, IMG_HEIGHT=4, zero-wait slave, 1-cycle read latency:
  - 64 reads total, in order addresses 0,4,..,28, then 56..84, then 112..140, then 168..196, then strip 2 from byte offset 24.
  - 4 filter_start pulses; 24 pixel_done accepted.
  - frame_done exactly once.
- master_waitrequest held high 5 cycles on the 3rd FILL read -> address 8 and master_read stable all 5 cycles, single issue. Total FILL reads still 24.
- After a LOAD completes -> shift_enable8 high exactly 8 cycles, then filter_start pulses the following cycle.
- Extra pixel_done pulses in FILL/SHIFT plus 7 pulses in PROC -> the 7th PROC pulse is ignored; transition happens on the 6th.
- IMG_WIDTH=7, start -> frame_done one cycle later, master_read never asserted.
